// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select and hazard (load-use bubble, dmem-wait freeze) controller for the 5-stage rv32i pipe.
// Optional cycle counters for bubbles and freezes are compiled in when HAZARD_PERF_CNT_EN is defined.
module hazard_forward_ctrl #(
    parameter int NUM_SRC      = 2,
    parameter int REG_IDX_W    = 5,
    parameter int LU_STALL_CYC = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC*REG_IDX_W-1:0]   id_ex_rs_i,
    input  logic [NUM_SRC-1:0]             id_ex_rs_used_i,
    input  logic [NUM_SRC*REG_IDX_W-1:0]   if_id_rs_i,
    input  logic [NUM_SRC-1:0]             if_id_rs_used_i,
    input  logic [REG_IDX_W-1:0]           id_ex_rd_i,
    input  logic                           id_ex_is_load_i,
    input  logic [REG_IDX_W-1:0]           ex_mem_rd_i,
    input  logic                           ex_mem_load_regfile_i,
    input  logic                           ex_mem_mem_req_i,
    input  logic                           dmem_resp_i,
    input  logic [REG_IDX_W-1:0]           mem_wb_rd_i,
    input  logic                           mem_wb_load_regfile_i,
    output logic [NUM_SRC*2-1:0]           fwd_sel_o,
    output logic                           stall_if_id_o,
    output logic                           bubble_id_ex_o,
    output logic                           freeze_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                    lu_stall_cnt_o,
    output logic [31:0]                    mem_wait_cnt_o
`endif
);

    localparam logic [1:0] FWD_ID_EX  = 2'd0;
    localparam logic [1:0] FWD_EX_MEM = 2'd1;
    localparam logic [1:0] FWD_MEM_WB = 2'd2;

    localparam int CNT_W = (LU_STALL_CYC > 2) ? $clog2(LU_STALL_CYC) : 1;
    localparam logic [CNT_W-1:0] LU_LAST = CNT_W'(LU_STALL_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD_USE,
        ST_MEM_WAIT
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       lu_cnt_reg, lu_cnt_next;
    logic [NUM_SRC*2-1:0]   held_sel_reg, held_sel_next;
    logic [NUM_SRC*2-1:0]   fwd_comb;
    logic [NUM_SRC-1:0]     lu_match;
    logic                   lu_hit;
    logic                   mem_wait;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic ex_hit;
            logic wb_hit;
            // x0 is hard-wired zero, so a write to it is never a forwarding source
            assign ex_hit = ex_mem_load_regfile_i && (ex_mem_rd_i != '0) && id_ex_rs_used_i[gi]
                            && (ex_mem_rd_i == id_ex_rs_i[gi*REG_IDX_W +: REG_IDX_W]);
            assign wb_hit = mem_wb_load_regfile_i && (mem_wb_rd_i != '0) && id_ex_rs_used_i[gi]
                            && (mem_wb_rd_i == id_ex_rs_i[gi*REG_IDX_W +: REG_IDX_W]);
            assign fwd_comb[gi*2 +: 2] = ex_hit ? FWD_EX_MEM : (wb_hit ? FWD_MEM_WB : FWD_ID_EX);
            assign lu_match[gi] = if_id_rs_used_i[gi]
                                  && (if_id_rs_i[gi*REG_IDX_W +: REG_IDX_W] == id_ex_rd_i);
        end
    endgenerate

    assign lu_hit   = id_ex_is_load_i && (id_ex_rd_i != '0) && (|lu_match);
    assign mem_wait = ex_mem_mem_req_i && !dmem_resp_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_RUN;
            lu_cnt_reg   <= '0;
            held_sel_reg <= {NUM_SRC{FWD_ID_EX}};
        end else begin
            state_reg    <= state_next;
            lu_cnt_reg   <= lu_cnt_next;
            held_sel_reg <= held_sel_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        lu_cnt_next    = lu_cnt_reg;
        held_sel_next  = held_sel_reg;
        fwd_sel_o      = fwd_comb;
        stall_if_id_o  = 1'b0;
        bubble_id_ex_o = 1'b0;
        freeze_o       = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (mem_wait) begin
                    freeze_o      = 1'b1;
                    held_sel_next = fwd_comb;
                    state_next    = ST_MEM_WAIT;
                end else if (lu_hit) begin
                    stall_if_id_o  = 1'b1;
                    bubble_id_ex_o = 1'b1;
                    if (LU_STALL_CYC > 1) begin
                        state_next  = ST_LOAD_USE;
                        lu_cnt_next = CNT_W'(1);
                    end
                end
            end
            ST_LOAD_USE: begin
                // lu_cnt is preserved across a freeze so the bubble sequence resumes afterwards
                if (mem_wait) begin
                    freeze_o      = 1'b1;
                    held_sel_next = fwd_comb;
                    state_next    = ST_MEM_WAIT;
                end else begin
                    stall_if_id_o  = 1'b1;
                    bubble_id_ex_o = 1'b1;
                    if (lu_cnt_reg == LU_LAST) begin
                        state_next  = ST_RUN;
                        lu_cnt_next = '0;
                    end else begin
                        lu_cnt_next = lu_cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_MEM_WAIT: begin
                fwd_sel_o = held_sel_reg;
                freeze_o  = !dmem_resp_i;
                if (dmem_resp_i) begin
                    state_next = (lu_cnt_reg != '0) ? ST_LOAD_USE : ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
        // Outputs go quiet the instant reset asserts, not at the next edge
        if (!rst) begin
            fwd_sel_o      = {NUM_SRC{FWD_ID_EX}};
            stall_if_id_o  = 1'b0;
            bubble_id_ex_o = 1'b0;
            freeze_o       = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lu_stall_cnt_o <= '0;
            mem_wait_cnt_o <= '0;
        end else begin
            if (bubble_id_ex_o && (lu_stall_cnt_o != 32'hFFFF_FFFF)) begin
                lu_stall_cnt_o <= lu_stall_cnt_o + 32'd1;
            end
            if (freeze_o && (mem_wait_cnt_o != 32'hFFFF_FFFF)) begin
                mem_wait_cnt_o <= mem_wait_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl (NUM_SRC=2, LU_STALL_CYC=2): vector table,
// directed multi-cycle sequences and a randomized run against a remaining-bubble-count model.
`timescale 1ns/100ps
module tb_hazard_forward_ctrl;

    localparam int LU = 2;
    localparam logic [1:0] S_ID = 2'd0;
    localparam logic [1:0] S_EX = 2'd1;
    localparam logic [1:0] S_WB = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  id_ex_rs;
    logic [1:0]  id_ex_used;
    logic [9:0]  if_id_rs;
    logic [1:0]  if_id_used;
    logic [4:0]  id_ex_rd;
    logic        is_load;
    logic [4:0]  ex_rd;
    logic        ex_wr;
    logic        mem_req;
    logic        resp;
    logic [4:0]  wb_rd;
    logic        wb_wr;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        bubble;
    logic        freeze;

    int total = 0;
    int bad   = 0;

    hazard_forward_ctrl #(
        .NUM_SRC(2),
        .REG_IDX_W(5),
        .LU_STALL_CYC(LU)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .id_ex_rs_i            (id_ex_rs),
        .id_ex_rs_used_i       (id_ex_used),
        .if_id_rs_i            (if_id_rs),
        .if_id_rs_used_i       (if_id_used),
        .id_ex_rd_i            (id_ex_rd),
        .id_ex_is_load_i       (is_load),
        .ex_mem_rd_i           (ex_rd),
        .ex_mem_load_regfile_i (ex_wr),
        .ex_mem_mem_req_i      (mem_req),
        .dmem_resp_i           (resp),
        .mem_wb_rd_i           (wb_rd),
        .mem_wb_load_regfile_i (wb_wr),
        .fwd_sel_o             (fwd_sel),
        .stall_if_id_o         (stall),
        .bubble_id_ex_o        (bubble),
        .freeze_o              (freeze)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] ex_rd;
        logic       ex_wr;
        logic [4:0] wb_rd;
        logic       wb_wr;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic [1:0] e0;
        logic [1:0] e1;
    } fwd_vec_t;

    fwd_vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_ex_rs = '0; id_ex_used = '0; if_id_rs = '0; if_id_used = '0;
        id_ex_rd = '0; is_load = 1'b0; ex_rd = '0; ex_wr = 1'b0;
        mem_req = 1'b0; resp = 1'b0; wb_rd = '0; wb_wr = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_ctl(input string name, input logic s, input logic b, input logic f);
        check({name, ".stall"}, stall, s);
        check({name, ".bubble"}, bubble, b);
        check({name, ".freeze"}, freeze, f);
        $display("%s: fwd=%h stall=%0d bubble=%0d freeze=%0d", name, fwd_sel, stall, bubble, freeze);
    endtask

    // Reference: forwarding select from the priority rules, operand by operand
    function automatic logic [3:0] model_fwd();
        logic [3:0] r;
        logic [4:0] rs;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            rs = id_ex_rs[i*5 +: 5];
            if (ex_wr && ex_rd != 0 && ex_rd == rs && id_ex_used[i])      r[i*2 +: 2] = S_EX;
            else if (wb_wr && wb_rd != 0 && wb_rd == rs && id_ex_used[i]) r[i*2 +: 2] = S_WB;
            else                                                           r[i*2 +: 2] = S_ID;
        end
        return r;
    endfunction

    function automatic bit model_lu_hit();
        bit h;
        h = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (if_id_used[i] && if_id_rs[i*5 +: 5] == id_ex_rd) h = 1'b1;
        end
        return is_load && id_ex_rd != 0 && h;
    endfunction

    int         lu_left;
    bit         in_wait;
    logic [3:0] held;

    initial begin
        logic [3:0] e_fwd;
        bit e_s, e_b, e_f;

        vecs[0] = '{5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 5'd0, 2'b11, S_EX, S_ID};
        vecs[1] = '{5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 2'b11, S_ID, S_ID};
        vecs[2] = '{5'd7, 1'b1, 5'd7, 1'b1, 5'd1, 5'd7, 2'b11, S_ID, S_EX};
        vecs[3] = '{5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 5'd7, 2'b11, S_WB, S_WB};
        vecs[4] = '{5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 5'd5, 2'b10, S_ID, S_EX};
        vecs[5] = '{5'd0, 1'b0, 5'd9, 1'b1, 5'd9, 5'd9, 2'b01, S_WB, S_ID};
        vecs[6] = '{5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 2'b11, S_ID, S_ID};
        vecs[7] = '{5'd3, 1'b1, 5'd4, 1'b1, 5'd4, 5'd3, 2'b11, S_WB, S_EX};

        // Reset: every output quiet even with hazards presented
        clear_inputs();
        next_cycle();
        ex_rd = 5'd5; ex_wr = 1'b1; id_ex_rs = {5'd0, 5'd5}; id_ex_used = 2'b01;
        is_load = 1'b1; id_ex_rd = 5'd5; if_id_rs = {5'd0, 5'd5}; if_id_used = 2'b01;
        mem_req = 1'b1;
        #1;
        check("reset.fwd", fwd_sel, 4'h0);
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        next_cycle();
        clear_inputs();
        rst = 1'b1;

        for (int v = 0; v < 8; v++) begin
            next_cycle();
            clear_inputs();
            ex_rd = vecs[v].ex_rd; ex_wr = vecs[v].ex_wr;
            wb_rd = vecs[v].wb_rd; wb_wr = vecs[v].wb_wr;
            id_ex_rs = {vecs[v].rs1, vecs[v].rs0}; id_ex_used = vecs[v].used;
            #1;
            check($sformatf("vec%0d.sel0", v), fwd_sel[1:0], vecs[v].e0);
            check($sformatf("vec%0d.sel1", v), fwd_sel[3:2], vecs[v].e1);
            check($sformatf("vec%0d.stall", v), stall, 1'b0);
            $display("vec %0d: fwd=%h", v, fwd_sel);
        end

        // Load-use with LU_STALL_CYC=2: two bubble cycles
        next_cycle(); clear_inputs();
        is_load = 1'b1; id_ex_rd = 5'd3; if_id_rs = {5'd0, 5'd3}; if_id_used = 2'b01;
        #1; check_ctl("lu.c0", 1'b1, 1'b1, 1'b0);
        next_cycle(); is_load = 1'b0;
        #1; check_ctl("lu.c1", 1'b1, 1'b1, 1'b0);
        next_cycle(); clear_inputs();
        #1; check_ctl("lu.c2", 1'b0, 1'b0, 1'b0);

        // dmem response four cycles late: freeze four cycles, selects held
        next_cycle(); clear_inputs();
        ex_rd = 5'd5; ex_wr = 1'b1; id_ex_rs = {5'd0, 5'd5}; id_ex_used = 2'b01; mem_req = 1'b1;
        #1; check("mw.c0.fwd", fwd_sel, 4'h1); check_ctl("mw.c0", 1'b0, 1'b0, 1'b1);
        for (int c = 1; c < 4; c++) begin
            next_cycle(); ex_rd = 5'd6;
            #1;
            check($sformatf("mw.c%0d.fwd", c), fwd_sel, 4'h1);
            check_ctl($sformatf("mw.c%0d", c), 1'b0, 1'b0, 1'b1);
        end
        next_cycle(); resp = 1'b1;
        #1; check("mw.c4.fwd", fwd_sel, 4'h1); check_ctl("mw.c4", 1'b0, 1'b0, 1'b0);
        next_cycle(); mem_req = 1'b0; resp = 1'b0;
        #1; check("mw.c5.fwd", fwd_sel, 4'h0); check_ctl("mw.c5", 1'b0, 1'b0, 1'b0);
        next_cycle(); mem_req = 1'b1; resp = 1'b1;
        #1; check_ctl("zl.c0", 1'b0, 1'b0, 1'b0);
        next_cycle(); clear_inputs();
        #1; check_ctl("zl.c1", 1'b0, 1'b0, 1'b0);

        // Load-use interrupted by a dmem wait, then the remaining bubble
        next_cycle(); clear_inputs();
        is_load = 1'b1; id_ex_rd = 5'd3; if_id_rs = {5'd0, 5'd3}; if_id_used = 2'b01;
        #1; check_ctl("lumw.c0", 1'b1, 1'b1, 1'b0);
        next_cycle(); is_load = 1'b0; mem_req = 1'b1;
        #1; check_ctl("lumw.c1", 1'b0, 1'b0, 1'b1);
        next_cycle(); resp = 1'b1;
        #1; check_ctl("lumw.c2", 1'b0, 1'b0, 1'b0);
        next_cycle(); mem_req = 1'b0; resp = 1'b0;
        #1; check_ctl("lumw.c3", 1'b1, 1'b1, 1'b0);
        next_cycle(); clear_inputs();
        #1; check_ctl("lumw.c4", 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a dmem wait
        next_cycle(); clear_inputs();
        ex_rd = 5'd5; ex_wr = 1'b1; id_ex_rs = {5'd0, 5'd5}; id_ex_used = 2'b01; mem_req = 1'b1;
        #1; check_ctl("rmw.c0", 1'b0, 1'b0, 1'b1);
        next_cycle();
        #1; check_ctl("rmw.c1", 1'b0, 1'b0, 1'b1);
        #1; rst = 1'b0;
        #1; check("rmw.rst.fwd", fwd_sel, 4'h0); check_ctl("rmw.rst", 1'b0, 1'b0, 1'b0);
        next_cycle(); mem_req = 1'b0;
        next_cycle(); rst = 1'b1;
        #1; check("rmw.rel.fwd", fwd_sel, 4'h1); check_ctl("rmw.rel", 1'b0, 1'b0, 1'b0);

        // Randomized run against the reference model
        next_cycle(); clear_inputs(); rst = 1'b0;
        next_cycle(); rst = 1'b1;
        lu_left = 0; in_wait = 1'b0; held = '0;
        for (int n = 0; n < 300; n++) begin
            if (n != 0) next_cycle();
            for (int i = 0; i < 2; i++) begin
                id_ex_rs[i*5 +: 5] = 5'($urandom_range(0, 3));
                if_id_rs[i*5 +: 5] = 5'($urandom_range(0, 3));
            end
            id_ex_used = 2'($urandom); if_id_used = 2'($urandom);
            id_ex_rd = 5'($urandom_range(0, 3)); is_load = ($urandom_range(0, 3) == 0);
            ex_rd = 5'($urandom_range(0, 3)); ex_wr = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 3)); wb_wr = 1'($urandom);
            mem_req = ($urandom_range(0, 3) == 0); resp = 1'($urandom);
            #1;
            e_fwd = model_fwd(); e_s = 1'b0; e_b = 1'b0; e_f = 1'b0;
            if (in_wait) begin
                e_fwd = held; e_f = !resp;
                if (resp) in_wait = 1'b0;
            end else if (mem_req && !resp) begin
                e_f = 1'b1; held = e_fwd; in_wait = 1'b1;
            end else if (lu_left > 0) begin
                e_s = 1'b1; e_b = 1'b1; lu_left--;
            end else if (model_lu_hit()) begin
                e_s = 1'b1; e_b = 1'b1; lu_left = LU - 1;
            end
            check($sformatf("rnd%0d.fwd", n), fwd_sel, e_fwd);
            check_ctl($sformatf("rnd%0d", n), e_s, e_b, e_f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
